lfsr_bit_scheduler: RTL

//  Shares one lfsr instance between NUM_REQ requesters. Each requester asks for a burst of random bits.
//  The block seeds the LFSR, arbitrates round-robin and steps the LFSR once per bit.

---
 rtl/lfsr_bit_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_bit_scheduler.sv
// lfsr_bit_scheduler: shares one external LFSR between NUM_REQ requesters.
// It seeds the LFSR, grants bursts round-robin and steps the LFSR once per bit.
// Each burst is packed into one response word on a valid/ready channel.
// Optional feature macro: LFSR_LOCKUP_RESEED_EN. When defined, an all-zero LFSR
// state seen in IDLE forces a reseed and sets the sticky lockup_seen flag.
module lfsr_bit_scheduler #(
    parameter int WIDTH   = 5,
    parameter int NUM_REQ = 4,
    parameter int OUT_W   = 16,
    parameter int LEN_W   = $clog2(OUT_W + 1),
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [OUT_W-1:0]         rsp_data,
    input  logic [WIDTH-1:0]         cfg_seed,
    input  logic [WIDTH-1:0]         cfg_taps,
    input  logic                     cfg_load,
    output logic                     lfsr_reinit,
    output logic                     lfsr_advance,
    output logic [WIDTH-1:0]         lfsr_initial_state,
    output logic [WIDTH-1:0]         lfsr_taps,
    input  logic                     lfsr_out,
    input  logic [WIDTH-1:0]         lfsr_state,
    output logic                     busy,
    output logic                     lockup_seen
);

    typedef enum logic [1:0] {
        SEED = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  data_q;
    logic [WIDTH-1:0]  taps_q;
    logic              reseed_pend_q;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand_idx;
    logic [LEN_W-1:0]  raw_len;
    logic [LEN_W-1:0]  grant_len;
    logic [ID_W-1:0]   next_ptr;
    logic              do_grant;
    logic              last_bit;
    logic              lockup_now;
    logic [WIDTH-1:0]  seed_value;

`ifdef LFSR_LOCKUP_RESEED_EN
    logic              lockup_q;

    assign lockup_now  = (lfsr_state == '0);
    assign seed_value  = (cfg_seed == '0) ? WIDTH'(1) : cfg_seed;
    assign lockup_seen = lockup_q;

    // Sticky record that the LFSR was found stuck at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockup_q <= 1'b0;
        end else if (state_q == IDLE && lockup_now) begin
            lockup_q <= 1'b1;
        end
    end
`else
    logic              unused_state;

    assign unused_state = ^lfsr_state;
    assign lockup_now   = 1'b0;
    assign seed_value   = cfg_seed;
    assign lockup_seen  = 1'b0;
`endif

    assign lfsr_taps = taps_q;
    assign last_bit  = ((cnt_q + LEN_W'(1)) == len_q);
    assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Round-robin search starting at the pointer, plus the clamped length of the winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        raw_len     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                raw_len = req_len[i*LEN_W +: LEN_W];
            end
        end
        grant_len = (raw_len > LEN_W'(OUT_W)) ? LEN_W'(OUT_W) : raw_len;
    end

    // Next-state and output decode; everything is held at zero while reset is asserted
    always_comb begin
        state_d            = state_q;
        req_ready          = '0;
        rsp_valid          = 1'b0;
        rsp_id             = '0;
        rsp_data           = '0;
        lfsr_reinit        = 1'b0;
        lfsr_advance       = 1'b0;
        lfsr_initial_state = '0;
        busy               = 1'b0;
        do_grant           = 1'b0;
        if (rst_n) begin
            busy = (state_q != IDLE);
            unique case (state_q)
                SEED: begin
                    lfsr_reinit        = 1'b1;
                    lfsr_initial_state = seed_value;
                    state_d            = IDLE;
                end
                IDLE: begin
                    if (reseed_pend_q || cfg_load || lockup_now) begin
                        state_d = SEED;
                    end else if (grant_found) begin
                        do_grant             = 1'b1;
                        req_ready[grant_idx] = 1'b1;
                        state_d              = (grant_len == '0) ? RESP : RUN;
                    end
                end
                RUN: begin
                    lfsr_advance = 1'b1;
                    if (last_bit) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_id    = id_q;
                    rsp_data  = data_q;
                    if (rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    // State register and burst bookkeeping: grant capture, bit packing, pending reseed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEED;
            ptr_q         <= '0;
            id_q          <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
            taps_q        <= '0;
            reseed_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                SEED: begin
                    taps_q        <= cfg_taps;
                    reseed_pend_q <= 1'b0;
                end
                IDLE: begin
                    if (do_grant) begin
                        id_q   <= grant_idx;
                        len_q  <= grant_len;
                        cnt_q  <= '0;
                        data_q <= '0;
                        ptr_q  <= next_ptr;
                    end
                end
                RUN: begin
                    data_q <= data_q | (OUT_W'(lfsr_out) << cnt_q);
                    cnt_q  <= cnt_q + LEN_W'(1);
                    if (cfg_load) begin
                        reseed_pend_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (cfg_load) begin
                        reseed_pend_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
